// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage that sits directly upstream of the main decoder.
//   It owns the PC, issues one word read at a time to instruction memory
//   (req/rvalid handshake) and presents the returned instruction to decode
//   over a valid/ready handshake. Branch/jump redirects from execute replace
//   the PC; any response still in flight for the old path is discarded.
//
// Ports
//   clk              in   1   rising-edge clock
//   reset            in   1   asynchronous, active-high reset
//   imem_req         out  1   read request, accepted by memory in the same cycle
//   imem_addr        out  32  word-aligned read address (current pc)
//   imem_rvalid      in   1   read data valid, >=1 cycle after imem_req
//   imem_rdata       in   32  read data
//   redirect         in   1   taken branch/jump, 1-cycle pulse
//   redirect_target  in   32  new pc, bits [1:0] forced to 00
//   instr_valid      out  1   instr/instr_pc/instr_pcplus4 valid for decode
//   instr            out  32  fetched instruction, NOP_INSTR while !instr_valid
//   instr_pc         out  32  address of instr
//   instr_pcplus4    out  32  instr_pc + 4 (mod 2^32)
//   id_ready         in   1   decode consumes instr when instr_valid & id_ready
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  input  logic        id_ready
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DROP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ip4_q, ip4_d;

  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign target_s   = {redirect_target[31:2], 2'b00};
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state and next-output logic; redirect outranks every other transition.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ip4_d   = ip4_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redirect) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_REQ: begin
        // The request leaving this cycle used the old pc, so a redirect
        // here must wait out its response before fetching the target.
        if (redirect) begin
          pc_d    = target_s;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target_s;
          if (imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_rvalid) begin
          state_d = S_VALID;
          valid_d = 1'b1;
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          ip4_d   = pc_plus4_s;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_VALID: begin
        if (redirect) begin
          // Instruction on the wrong path: withdraw it even if decode
          // is ready this cycle.
          pc_d    = target_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc_plus4_s;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else begin
          state_d = S_VALID;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        // Unreachable encodings recover to a clean boot.
        state_d = S_BOOT;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    endcase
    // Request is registered so it is high exactly while the state is REQ.
    req_d = (state_d == S_REQ);
  end

  // State, pc and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      ip4_q   <= RESET_PC + 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ip4_q   <= ip4_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign instr_valid   = valid_q;
  assign instr         = instr_q;
  assign instr_pc      = ipc_q;
  assign instr_pcplus4 = ip4_q;

endmodule
